// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit resolved per clock.
// Latency: Done pulses in the cycle after edge k+WIDTH+1 (k = ld accept edge).
// Optional DIV_ZERO_DETECT_EN: adds DZ and short-circuits B==0 to FIN.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             Busy,
`ifdef DIV_ZERO_DETECT_EN
  output logic             DZ,
`endif
  output logic             Done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_busy;
  logic             r_done;
`ifdef DIV_ZERO_DETECT_EN
  logic             r_dz;
  logic             r_dz_pend;
`endif

  // Trial subtraction: partial remainder shifted left with the next dividend
  // bit, minus the divisor. One extra guard bit makes the borrow explicit.
  logic [WIDTH:0]   w_shift;
  logic [WIDTH+1:0] w_diff;
  logic             w_fits;

  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_diff  = {1'b0, w_shift} - {2'b00, r_b};
  assign w_fits  = ~w_diff[WIDTH+1];

  assign Q    = r_q;
  assign R    = r_r;
  assign Busy = r_busy;
  assign Done = r_done;
`ifdef DIV_ZERO_DETECT_EN
  assign DZ   = r_dz;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: IDLE accepts ld, RUN iterates WIDTH times, FIN publishes.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (ld) begin
          w_next = S_RUN;
`ifdef DIV_ZERO_DETECT_EN
          if (B == '0) begin
            w_next = S_FIN;
          end
`endif
        end
      end
      S_RUN: begin
        if (r_cnt == LAST_CNT) begin
          w_next = S_FIN;
        end
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: operand capture, restoring iterations, result publication.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_b    <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_cnt  <= '0;
      r_q    <= '0;
      r_r    <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
      r_dz      <= 1'b0;
      r_dz_pend <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ld) begin
            r_b    <= B;
            r_rem  <= '0;
            r_quo  <= A;
            r_cnt  <= '0;
            r_busy <= 1'b1;
`ifdef DIV_ZERO_DETECT_EN
            // Zero divisor: the result is known up front, skip the iterations.
            r_dz_pend <= (B == '0);
            if (B == '0) begin
              r_quo <= '1;
              r_rem <= A;
            end
`endif
          end
        end
        S_RUN: begin
          if (w_fits) begin
            r_rem <= w_diff[WIDTH-1:0];
          end else begin
            r_rem <= w_shift[WIDTH-1:0];
          end
          r_quo <= {r_quo[WIDTH-2:0], w_fits};
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIN: begin
          r_q    <= r_quo;
          r_r    <= r_rem;
          r_done <= 1'b1;
          r_busy <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
          r_dz   <= r_dz_pend;
`endif
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized checks of seq_divider at WIDTH=8 and WIDTH=16.
// Expected results are hand-computed constants or integer / and % in the bench.
// Honours DIV_ZERO_DETECT_EN when defined for the build.
module tb_seq_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       ld;
  logic [7:0] A, B, Q, R;
  logic       Busy, Done;
`ifdef DIV_ZERO_DETECT_EN
  logic       DZ;
`endif

  logic        ld16;
  logic [15:0] A16, B16, Q16, R16;
  logic        Busy16, Done16;
`ifdef DIV_ZERO_DETECT_EN
  logic        DZ16;
`endif

  int checks   = 0;
  int failures = 0;

  seq_divider #(.WIDTH(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .ld  (ld),
    .A   (A),
    .B   (B),
    .Q   (Q),
    .R   (R),
    .Busy(Busy),
`ifdef DIV_ZERO_DETECT_EN
    .DZ  (DZ),
`endif
    .Done(Done)
  );

  seq_divider #(.WIDTH(16)) u_dut16 (
    .clk (clk),
    .rst (rst),
    .ld  (ld16),
    .A   (A16),
    .B   (B16),
    .Q   (Q16),
    .R   (R16),
    .Busy(Busy16),
`ifdef DIV_ZERO_DETECT_EN
    .DZ  (DZ16),
`endif
    .Done(Done16)
  );

  // Issue one ld on the 8-bit unit and wait (bounded) for Done.
  // lat = number of edges after the accept edge at which Done is seen (0 = timeout).
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] q, output logic [7:0] r, output int lat,
                        output logic busy_k, output logic busy_at_done, output logic done_next);
    @(negedge clk);
    A = a; B = b; ld = 1'b1;
    @(posedge clk); #1;
    ld = 1'b0;
    busy_k = Busy;
    lat = 0; q = '0; r = '0; busy_at_done = 1'b0; done_next = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (Done) begin
        lat = i; q = Q; r = R; busy_at_done = Busy;
        break;
      end
    end
    if (lat != 0) begin
      @(posedge clk); #1;
      done_next = Done;
    end
  endtask

  task automatic run_op16(input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] q, output logic [15:0] r, output int lat,
                          output logic done_next);
    @(negedge clk);
    A16 = a; B16 = b; ld16 = 1'b1;
    @(posedge clk); #1;
    ld16 = 1'b0;
    lat = 0; q = '0; r = '0; done_next = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (Done16) begin
        lat = i; q = Q16; r = R16;
        break;
      end
    end
    if (lat != 0) begin
      @(posedge clk); #1;
      done_next = Done16;
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({Q, R, Busy, Done} !== 18'd0) begin
      failures++;
      $display("FAIL reset_in_rst: got Q=%0d R=%0d Busy=%b Done=%b, want all 0", Q, R, Busy, Done);
    end
    @(negedge clk); rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({Q, R, Busy, Done, Q16, R16, Busy16, Done16} !== 52'd0) begin
      failures++;
      $display("FAIL reset_after_release: got Q=%0d R=%0d Busy=%b Done=%b Q16=%0d R16=%0d", Q, R, Busy, Done, Q16, R16);
    end
`ifdef DIV_ZERO_DETECT_EN
    checks++;
    if (DZ !== 1'b0) begin
      failures++;
      $display("FAIL reset_dz: got %b want 0", DZ);
    end
`endif
  endtask

  task automatic test_basic();
    logic [7:0] q, r;
    int lat;
    logic bk, bd, dn;
    run_op(8'd100, 8'd7, q, r, lat, bk, bd, dn);
    checks++;
    if (lat !== 9) begin failures++; $display("FAIL basic_latency: got %0d want 9", lat); end
    checks++;
    if (q !== 8'd14) begin failures++; $display("FAIL basic_q: got %0d want 14", q); end
    checks++;
    if (r !== 8'd2) begin failures++; $display("FAIL basic_r: got %0d want 2", r); end
    checks++;
    if (bk !== 1'b1) begin failures++; $display("FAIL basic_busy_after_accept: got %b want 1", bk); end
    checks++;
    if (bd !== 1'b0) begin failures++; $display("FAIL basic_busy_with_done: got %b want 0", bd); end
    checks++;
    if (dn !== 1'b0) begin failures++; $display("FAIL basic_done_width: got %b want 0", dn); end
  endtask

  task automatic test_patterns();
    logic [7:0] va [3] = '{8'd255, 8'd5, 8'd0};
    logic [7:0] vb [3] = '{8'd1,   8'd9, 8'd3};
    logic [7:0] vq [3] = '{8'd255, 8'd0, 8'd0};
    logic [7:0] vr [3] = '{8'd0,   8'd5, 8'd0};
    logic [7:0] q, r;
    int lat;
    logic bk, bd, dn;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], q, r, lat, bk, bd, dn);
      checks++;
      if (q !== vq[i] || r !== vr[i] || lat !== 9) begin
        failures++;
        $display("FAIL pattern_%0d: got Q=%0d R=%0d lat=%0d want Q=%0d R=%0d lat=9", i, q, r, lat, vq[i], vr[i]);
      end
`ifdef DIV_ZERO_DETECT_EN
      checks++;
      if (DZ !== 1'b0) begin failures++; $display("FAIL pattern_dz_%0d: got %b want 0", i, DZ); end
`endif
    end
  endtask

  task automatic test_div_zero();
    logic [7:0] q, r;
    int lat;
    logic bk, bd, dn;
    run_op(8'd200, 8'd0, q, r, lat, bk, bd, dn);
    checks++;
    if (q !== 8'd255 || r !== 8'd200) begin
      failures++;
      $display("FAIL divzero_result: got Q=%0d R=%0d want Q=255 R=200", q, r);
    end
`ifdef DIV_ZERO_DETECT_EN
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL divzero_latency: got %0d want 1", lat); end
    checks++;
    if (DZ !== 1'b1) begin failures++; $display("FAIL divzero_dz: got %b want 1", DZ); end
    run_op(8'd9, 8'd2, q, r, lat, bk, bd, dn);
    checks++;
    if (DZ !== 1'b0 || q !== 8'd4 || r !== 8'd1) begin
      failures++;
      $display("FAIL divzero_clear: got DZ=%b Q=%0d R=%0d want DZ=0 Q=4 R=1", DZ, q, r);
    end
`else
    checks++;
    if (lat !== 9) begin failures++; $display("FAIL divzero_latency: got %0d want 9", lat); end
`endif
    checks++;
    if (dn !== 1'b0) begin failures++; $display("FAIL divzero_done_width: got %b want 0", dn); end
  endtask

  // ld held high: accept edges 0,10,20,30 -> Done seen after edges 9,19,29,39.
  task automatic test_back_to_back();
    int ndone = 0;
    logic prev_done = 1'b0;
    @(negedge clk);
    A = 8'd50; B = 8'd5; ld = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      if (Done) begin
        ndone++;
        checks++;
        if ((cyc % 10) != 9 || Q !== 8'd10 || R !== 8'd0) begin
          failures++;
          $display("FAIL b2b_result: cycle %0d got Q=%0d R=%0d want cycle%%10=9 Q=10 R=0", cyc, Q, R);
        end
        checks++;
        if (prev_done !== 1'b0 || Busy !== 1'b0) begin
          failures++;
          $display("FAIL b2b_done_shape: cycle %0d prev_done=%b Busy=%b want 0 0", cyc, prev_done, Busy);
        end
      end
      prev_done = Done;
      if (cyc == 3) begin A = 8'd99; B = 8'd3; end
      if (cyc == 7) begin A = 8'd50; B = 8'd5; end
      if (cyc == 40) ld = 1'b0;
    end
    checks++;
    if (ndone !== 4) begin failures++; $display("FAIL b2b_count: got %0d want 4", ndone); end
    repeat (12) @(posedge clk);
  endtask

  task automatic test_reset_abort();
    logic [7:0] q, r;
    int lat;
    logic bk, bd, dn;
    int ndone = 0;
    @(negedge clk);
    A = 8'd100; B = 8'd7; ld = 1'b1;
    @(posedge clk); #1;
    ld = 1'b0;
    repeat (4) @(posedge clk);
    #1; rst = 1'b1;
    #1;
    checks++;
    if ({Q, R, Busy, Done} !== 18'd0) begin
      failures++;
      $display("FAIL abort_immediate: got Q=%0d R=%0d Busy=%b Done=%b want all 0", Q, R, Busy, Done);
    end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (Done || Busy) ndone++;
    end
    checks++;
    if (ndone !== 0) begin failures++; $display("FAIL abort_no_done: got %0d active cycles want 0", ndone); end
    run_op(8'd100, 8'd7, q, r, lat, bk, bd, dn);
    checks++;
    if (q !== 8'd14 || r !== 8'd2 || lat !== 9) begin
      failures++;
      $display("FAIL abort_recover: got Q=%0d R=%0d lat=%0d want Q=14 R=2 lat=9", q, r, lat);
    end
  endtask

  task automatic test_random();
    logic [7:0] a, b, q, r;
    logic [15:0] a16, b16, q16, r16;
    int lat;
    logic bk, bd, dn;
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(1, 255));
      run_op(a, b, q, r, lat, bk, bd, dn);
      checks++;
      if (q !== a / b || r !== a % b || lat !== 9 || dn !== 1'b0) begin
        failures++;
        $display("FAIL rand8: A=%0d B=%0d got Q=%0d R=%0d lat=%0d dn=%b want Q=%0d R=%0d lat=9 dn=0",
                 a, b, q, r, lat, dn, a / b, a % b);
      end
    end
    for (int i = 0; i < 1000; i++) begin
      a16 = 16'($urandom_range(0, 65535));
      b16 = (i % 4 == 0) ? 16'($urandom_range(1, 255)) : 16'($urandom_range(1, 65535));
      run_op16(a16, b16, q16, r16, lat, dn);
      checks++;
      if (q16 !== a16 / b16 || r16 !== a16 % b16 || lat !== 17 || dn !== 1'b0) begin
        failures++;
        $display("FAIL rand16: A=%0d B=%0d got Q=%0d R=%0d lat=%0d dn=%b want Q=%0d R=%0d lat=17 dn=0",
                 a16, b16, q16, r16, lat, dn, a16 / b16, a16 % b16);
      end
    end
  endtask

  initial begin
    rst = 1'b1; ld = 1'b0; A = '0; B = '0;
    ld16 = 1'b0; A16 = '0; B16 = '0;
    test_reset();
    test_basic();
    test_patterns();
    test_div_zero();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
